// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forward control for the kianv five-stage core.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_events counters.
module hazard_unit #(
  parameter int MEM_TIMEOUT = 1024,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [1:0] ResultSrcE,
  input  logic       PCSrcE,
  input  logic       MemReqM,
  input  logic       mem_ready,
  input  logic       MultiCycleE,
  input  logic       MultiCycleDoneE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic       MemTimeout
);

  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam bit TO_EN = (MEM_TIMEOUT != 0);
  localparam int TO_LAST_I =
    (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_LAST =
    TO_LAST_I[CNT_W-1:0];

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    MC_WAIT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             post_rst;
  logic             gstall;
  logic             lw_stall;
  logic             pc_flush;
  logic             lw_hold;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
      ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
      ForwardBE = 2'b01;
  end

  assign ForwardAD = RegWriteW && RdW != 5'd0
                     && RdW == Rs1D;
  assign ForwardBD = RegWriteW && RdW != 5'd0
                     && RdW == Rs2D;

  assign lw_stall = (ResultSrcE == RESULT_MEM)
                    && RegWriteE && RdE != 5'd0
                    && (RdE == Rs1D || RdE == Rs2D);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= RUN;
      cnt      <= '0;
      post_rst <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      post_rst <= 1'b0;
    end
  end

  // The entry cycle in RUN already counts as the first wait cycle.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    gstall     = 1'b0;
    MemTimeout = 1'b0;
    if (!post_rst) begin
      unique case (state)
        RUN: begin
          if (MemReqM && !mem_ready) begin
            gstall   = 1'b1;
            state_nx = MEM_WAIT;
            cnt_nx   = CNT_W'(1);
          end else if (MultiCycleE && !MultiCycleDoneE) begin
            gstall   = 1'b1;
            state_nx = MC_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_nx = RUN;
            cnt_nx   = '0;
          end else if (TO_EN && cnt >= TO_LAST) begin
            MemTimeout = 1'b1;
            state_nx   = RUN;
            cnt_nx     = '0;
          end else begin
            gstall = 1'b1;
            cnt_nx = cnt + CNT_W'(1);
          end
        end
        MC_WAIT: begin
          if (MultiCycleDoneE) state_nx = RUN;
          else                 gstall   = 1'b1;
        end
        default: begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign pc_flush = !post_rst && !gstall && PCSrcE;
  assign lw_hold  = !post_rst && !gstall && !PCSrcE
                    && lw_stall;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    unique case (1'b1)
      post_rst: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      gstall: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end
      pc_flush: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      lw_hold: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallD)
        stall_cycles <= stall_cycles + 32'd1;
      if (pc_flush)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized + directed stimulus for hazard_unit,
// scoreboard queue filled by the driver, drained by a negedge monitor.
module tb_hazard_unit;

  localparam int TO = 8;
  localparam logic [1:0] RES_MEM = 2'b01;

  typedef struct packed {
    logic [3:0] stall;
    logic [1:0] flush;
    logic [1:0] fae;
    logic [1:0] fbe;
    logic       fad;
    logic       fbd;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MemReqM, mem_ready;
  logic       MultiCycleE, MultiCycleDoneE;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD;
  logic       MemTimeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t sb[$];

  bit m_post = 1'b1;
  bit m_mem = 1'b0;
  bit m_mc = 1'b0;
  int m_waited = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .mem_ready(mem_ready),
    .MultiCycleE(MultiCycleE), .MultiCycleDoneE(MultiCycleDoneE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .MemTimeout(MemTimeout)
  );

  function automatic logic [1:0] fwd_e(logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic fwd_d(logic [4:0] rs);
    return RegWriteW && RdW != 0 && RdW == rs;
  endfunction

  task automatic idle();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW} = '0;
    ResultSrcE = 2'b00;
    {PCSrcE, MemReqM, mem_ready} = '0;
    {MultiCycleE, MultiCycleDoneE} = '0;
  endtask

  task automatic rand_in();
    Rs1D = 5'($urandom_range(0, 3));
    Rs2D = 5'($urandom_range(0, 3));
    Rs1E = 5'($urandom_range(0, 3));
    Rs2E = 5'($urandom_range(0, 3));
    RdE = 5'($urandom_range(0, 3));
    RdM = 5'($urandom_range(0, 3));
    RdW = 5'($urandom_range(0, 3));
    RegWriteE = 1'($urandom_range(0, 1));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 3));
    PCSrcE = ($urandom_range(0, 4) == 0);
    MemReqM = ($urandom_range(0, 2) == 0);
    mem_ready = ($urandom_range(0, 3) == 0);
    MultiCycleE = ($urandom_range(0, 5) == 0);
    MultiCycleDoneE = ($urandom_range(0, 2) == 0);
  endtask

  // Reference: per cycle, decide from the wait situation and the
  // priority rules what the pipeline must see, then advance one edge.
  task automatic step();
    exp_t e;
    bit gs, lw, to, nmem, nmc;
    int nw;
    if (!resetn) begin
      m_post = 1; m_mem = 0; m_mc = 0; m_waited = 0;
      m_stalls = 0; m_flushes = 0;
    end
    e = '0; gs = 0; to = 0;
    nmem = m_mem; nmc = m_mc; nw = m_waited;
    e.fae = fwd_e(Rs1E);
    e.fbe = fwd_e(Rs2E);
    e.fad = fwd_d(Rs1D);
    e.fbd = fwd_d(Rs2D);
    if (m_post) begin
      e.flush = 2'b11;
    end else begin
      if (m_mem) begin
        if (mem_ready) begin
          nmem = 0; nw = 0;
        end else if (TO != 0 && m_waited + 1 >= TO) begin
          to = 1; nmem = 0; nw = 0;
        end else begin
          gs = 1; nw = m_waited + 1;
        end
      end else if (m_mc) begin
        if (MultiCycleDoneE) nmc = 0;
        else gs = 1;
      end else if (MemReqM && !mem_ready) begin
        gs = 1; nmem = 1; nw = 1;
      end else if (MultiCycleE && !MultiCycleDoneE) begin
        gs = 1; nmc = 1;
      end
      lw = (ResultSrcE == RES_MEM) && RegWriteE && RdE != 0
           && (RdE == Rs1D || RdE == Rs2D);
      if (gs) begin
        e.stall = 4'b1111;
      end else if (PCSrcE) begin
        e.flush = 2'b11;
        m_flushes++;
      end else if (lw) begin
        e.stall = 4'b1100;
        e.flush = 2'b01;
      end
      if (e.stall[2]) m_stalls++;
      e.tmo = to;
    end
    sb.push_back(e);
    @(posedge clk);
    if (resetn) begin
      m_post = 0; m_mem = nmem; m_mc = nmc; m_waited = nw;
    end
    #1;
  endtask

  task automatic chk(string nm, int a, int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, a, x);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall", int'({StallF, StallD, StallE, StallM}),
            int'(e.stall));
        chk("flush", int'({FlushD, FlushE}), int'(e.flush));
        chk("fwd_e", int'({ForwardAE, ForwardBE}),
            int'({e.fae, e.fbe}));
        chk("fwd_d", int'({ForwardAD, ForwardBD}),
            int'({e.fad, e.fbd}));
        chk("timeout", int'(MemTimeout), int'(e.tmo));
        cyc++;
      end
    end
  end

  initial begin : driver
    resetn = 1'b0;
    idle();
    @(posedge clk);
    #1;
    repeat (3) step();
    resetn = 1'b1;
    repeat (3) step();

    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    step();
    RdM = 0;
    step();
    Rs2D = 5;
    step();
    idle();

    ResultSrcE = RES_MEM; RdE = 3; RegWriteE = 1; Rs2D = 3;
    step();
    PCSrcE = 1;
    step();
    idle();
    step();

    MemReqM = 1;
    repeat (4) step();
    mem_ready = 1;
    step();
    idle();
    step();

    MemReqM = 1;
    repeat (10) step();
    idle();
    repeat (2) step();

    MultiCycleE = 1; PCSrcE = 1;
    repeat (3) step();
    MultiCycleDoneE = 1;
    step();
    idle();
    step();

    repeat (2000) begin
      rand_in();
      if ($urandom_range(0, 60) == 0) begin
        MemReqM = 1;
        mem_ready = 0;
        repeat ($urandom_range(5, 12)) step();
      end
      step();
    end

    idle();
    resetn = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    repeat (200) begin
      rand_in();
      step();
    end
    idle();
    step();

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0",
               sb.size());
    end
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_cycles", int'(stall_cycles), m_stalls);
    chk("flush_events", int'(flush_events), m_flushes);
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
